// File: rtl/io_bus_arbiter.sv
// Three-way IO bus arbiter: interrupt-vector (0) > execute (1) / fetch (2) round-robin.
// One registered downstream transaction at a time, with response timeout and flush discard.
module io_bus_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clean,
  input  logic        int_only,
  input  logic        req0_taskValid,
  input  logic [39:0] req0_address,
  input  logic        req0_rwCtrl,
  input  logic [1:0]  req0_widthCtr,
  input  logic [63:0] req0_writeBus,
  output logic        req0_taskReady,
  output logic        req0_taskError,
  output logic [63:0] req0_readBus,
  input  logic        req1_taskValid,
  input  logic [39:0] req1_address,
  input  logic        req1_rwCtrl,
  input  logic [1:0]  req1_widthCtr,
  input  logic [63:0] req1_writeBus,
  output logic        req1_taskReady,
  output logic        req1_taskError,
  output logic [63:0] req1_readBus,
  input  logic        req2_taskValid,
  input  logic [39:0] req2_address,
  input  logic        req2_rwCtrl,
  input  logic [1:0]  req2_widthCtr,
  input  logic [63:0] req2_writeBus,
  output logic        req2_taskReady,
  output logic        req2_taskError,
  output logic [63:0] req2_readBus,
  output logic        dn_taskValid,
  output logic [39:0] dn_address,
  output logic        dn_rwCtrl,
  output logic [1:0]  dn_widthCtr,
  output logic [63:0] dn_writeBus,
  input  logic        dn_taskReady,
  input  logic        dn_taskError,
  input  logic [63:0] dn_readBus,
  output logic [1:0]  grant
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          rr_fetch_q, rr_fetch_d;  // 1: fetch wins the next execute/fetch tie
  logic          discard_q, discard_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dn_valid_q, dn_valid_d;
  logic [39:0]   dn_addr_q, dn_addr_d;
  logic          dn_rw_q, dn_rw_d;
  logic [1:0]    dn_width_q, dn_width_d;
  logic [63:0]   dn_wdata_q, dn_wdata_d;
  logic [2:0]    rsp_ready_q, rsp_ready_d;
  logic [2:0]    rsp_err_q, rsp_err_d;
  logic [63:0]   rsp_data_q, rsp_data_d;

  logic       elig1, elig2, any_elig;
  logic [1:0] winner;
  logic [2:0] owner_oh;
  logic       drop;

  always_comb begin
    elig1    = req1_taskValid & ~int_only;
    elig2    = req2_taskValid & ~int_only;
    any_elig = req0_taskValid | elig1 | elig2;
    winner   = 2'd0;
    if (!req0_taskValid) begin
      if (elig1 && elig2) winner = rr_fetch_q ? 2'd2 : 2'd1;
      else if (elig1)     winner = 2'd1;
      else if (elig2)     winner = 2'd2;
    end
  end

  always_comb begin
    case (grant_q)
      2'd0:    owner_oh = 3'b001;
      2'd1:    owner_oh = 3'b010;
      2'd2:    owner_oh = 3'b100;
      default: owner_oh = 3'b000;
    endcase
  end

  // A flush in the completing cycle discards the response just like an earlier one.
  assign drop = discard_q | (clean & (grant_q != 2'd0));

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_fetch_d  = rr_fetch_q;
    discard_d   = discard_q;
    cnt_d       = cnt_q;
    dn_valid_d  = dn_valid_q;
    dn_addr_d   = dn_addr_q;
    dn_rw_d     = dn_rw_q;
    dn_width_d  = dn_width_q;
    dn_wdata_d  = dn_wdata_q;
    rsp_ready_d = rsp_ready_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (any_elig) begin
          dn_valid_d = 1'b1;
          grant_d    = winner;
          cnt_d      = '0;
          discard_d  = 1'b0;
          state_d    = BUSY;
          case (winner)
            2'd1: begin
              dn_addr_d  = req1_address;
              dn_rw_d    = req1_rwCtrl;
              dn_width_d = req1_widthCtr;
              dn_wdata_d = req1_writeBus;
              rr_fetch_d = 1'b1;
            end
            2'd2: begin
              dn_addr_d  = req2_address;
              dn_rw_d    = req2_rwCtrl;
              dn_width_d = req2_widthCtr;
              dn_wdata_d = req2_writeBus;
              rr_fetch_d = 1'b0;
            end
            default: begin
              dn_addr_d  = req0_address;
              dn_rw_d    = req0_rwCtrl;
              dn_width_d = req0_widthCtr;
              dn_wdata_d = req0_writeBus;
            end
          endcase
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (clean && grant_q != 2'd0) discard_d = 1'b1;
        if (dn_taskReady || cnt_q == CNT_LAST) begin
          dn_valid_d = 1'b0;
          dn_addr_d  = '0;
          dn_rw_d    = 1'b0;
          dn_width_d = '0;
          dn_wdata_d = '0;
          state_d    = RESP;
          if (!drop) begin
            rsp_ready_d = owner_oh;
            rsp_err_d   = dn_taskReady ? ({3{dn_taskError}} & owner_oh) : owner_oh;
            rsp_data_d  = dn_taskReady ? dn_readBus : '0;
          end
        end
      end
      RESP: begin
        rsp_ready_d = '0;
        rsp_err_d   = '0;
        rsp_data_d  = '0;
        grant_d     = 2'd3;
        discard_d   = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      grant_q     <= 2'd3;
      rr_fetch_q  <= 1'b0;
      discard_q   <= 1'b0;
      cnt_q       <= '0;
      dn_valid_q  <= 1'b0;
      dn_addr_q   <= '0;
      dn_rw_q     <= 1'b0;
      dn_width_q  <= '0;
      dn_wdata_q  <= '0;
      rsp_ready_q <= '0;
      rsp_err_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_fetch_q  <= rr_fetch_d;
      discard_q   <= discard_d;
      cnt_q       <= cnt_d;
      dn_valid_q  <= dn_valid_d;
      dn_addr_q   <= dn_addr_d;
      dn_rw_q     <= dn_rw_d;
      dn_width_q  <= dn_width_d;
      dn_wdata_q  <= dn_wdata_d;
      rsp_ready_q <= rsp_ready_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign dn_taskValid   = dn_valid_q;
  assign dn_address     = dn_addr_q;
  assign dn_rwCtrl      = dn_rw_q;
  assign dn_widthCtr    = dn_width_q;
  assign dn_writeBus    = dn_wdata_q;
  assign grant          = grant_q;
  assign req0_taskReady = rsp_ready_q[0];
  assign req1_taskReady = rsp_ready_q[1];
  assign req2_taskReady = rsp_ready_q[2];
  assign req0_taskError = rsp_err_q[0];
  assign req1_taskError = rsp_err_q[1];
  assign req2_taskError = rsp_err_q[2];
  assign req0_readBus   = {64{rsp_ready_q[0]}} & rsp_data_q;
  assign req1_readBus   = {64{rsp_ready_q[1]}} & rsp_data_q;
  assign req2_readBus   = {64{rsp_ready_q[2]}} & rsp_data_q;

endmodule
